bp_me_io_cmd_arbiter: RTL and testbench

Parametrised N-source arbiter that merges `bp_cce_mem_msg_s` command streams from host-side agents (NBF loader, CCE config loader, debug/trace injectors) onto one IO command port. It replaces the ad hoc fixed two-way mux in the trace-demo testbench. It supports fixed-priority and round-robin grant, per-source enable gating, and a bounded outstanding-request count. Responses return in order and are routed to the issuing source by a source-ID FIFO. It sits between the host-side agents and `bp_me_cce_to_mem_link_bidir`.

---
 rtl/bp_me_pkg.sv | 27 ++
 rtl/bp_me_arb_id_fifo.sv | 53 +++++
 rtl/bp_me_io_cmd_arbiter.sv | 95 +++++++++
 tb/tb_bp_me_io_cmd_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared types for the IO command arbiter: arbitration modes, platform
// configurations, and the message-width lookup derived from them.
package bp_me_pkg;

  typedef enum logic {e_arb_fixed, e_arb_rr} bp_me_arb_mode_e;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_unicore_cfg,
    e_bp_multicore_cfg
  } bp_params_e;

  // Width of a bp_cce_mem_msg_s (header plus data) for a given platform configuration.
  function automatic int bp_me_mem_msg_width(bp_params_e cfg);
    case (cfg)
      e_bp_unicore_cfg:   return 128;
      e_bp_multicore_cfg: return 192;
      default:            return 64;
    endcase
  endfunction

  // Index width that never collapses to zero bits for single-entry structures.
  function automatic int bp_me_safe_clog2(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_me_arb_id_fifo.sv
// Circular FIFO holding the source index of each in-flight command so that
// in-order responses can be steered back to the source that issued them.
module bp_me_arb_id_fifo
  import bp_me_pkg::*;
#(
  parameter int depth_p = 4,
  parameter int width_p = 1,
  localparam int cnt_w_lp = $clog2(depth_p + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [width_p-1:0]  push_id,
  input  logic                pop,
  output logic [width_p-1:0]  head_id,
  output logic                full,
  output logic                empty,
  output logic [cnt_w_lp-1:0] count
);

  localparam int ptr_w_lp = bp_me_safe_clog2(depth_p);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(depth_p - 1);
  localparam logic [cnt_w_lp-1:0] depth_lp = cnt_w_lp'(depth_p);

  logic [width_p-1:0]  mem [depth_p];
  logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
  logic                do_push, do_pop;

  assign full    = (count == depth_lp);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = mem[rd_ptr];

  // Storage needs no reset: an empty FIFO never presents its head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == last_ptr_lp) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == last_ptr_lp) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/bp_me_io_cmd_arbiter.sv
// Merges N host-side command streams onto one IO command port with fixed or
// round-robin grant, and routes in-order responses back via a source-ID FIFO.
module bp_me_io_cmd_arbiter
  import bp_me_pkg::*;
#(
  parameter bp_params_e      bp_params_p       = e_bp_default_cfg,
  parameter int              num_src_p         = 2,
  parameter int              max_outstanding_p = 4,
  parameter bp_me_arb_mode_e arb_mode_p        = e_arb_fixed,
  localparam int mem_msg_width_lp = bp_me_mem_msg_width(bp_params_p),
  localparam int out_w_lp         = $clog2(max_outstanding_p + 1)
) (
  input  logic                                         clk_i,
  input  logic                                         reset_i,
  input  logic [num_src_p-1:0]                         src_en_i,
  input  logic [num_src_p-1:0][mem_msg_width_lp-1:0]   src_cmd_i,
  input  logic [num_src_p-1:0]                         src_cmd_v_i,
  output logic [num_src_p-1:0]                         src_cmd_yumi_o,
  output logic [mem_msg_width_lp-1:0]                  src_resp_o,
  output logic [num_src_p-1:0]                         src_resp_v_o,
  input  logic [num_src_p-1:0]                         src_resp_ready_i,
  output logic [mem_msg_width_lp-1:0]                  cmd_o,
  output logic                                         cmd_v_o,
  input  logic                                         cmd_ready_i,
  input  logic [mem_msg_width_lp-1:0]                  resp_i,
  input  logic                                         resp_v_i,
  output logic                                         resp_yumi_o,
  output logic [out_w_lp-1:0]                          outstanding_o,
  output logic                                         idle_o
);

  localparam int id_w_lp = bp_me_safe_clog2(num_src_p);
  localparam logic [id_w_lp:0]   num_src_lp = (id_w_lp + 1)'(num_src_p);
  localparam logic [id_w_lp-1:0] last_src_lp = id_w_lp'(num_src_p - 1);

  logic [num_src_p-1:0] eligible, rotated;
  logic [id_w_lp-1:0]   rr_ptr_r, rr_base, rot_idx, grant, head;
  logic [id_w_lp:0]     grant_sum;
  logic                 any_eligible, handshake, fifo_full, fifo_empty, resp_live;

  assign eligible     = src_en_i & src_cmd_v_i;
  assign any_eligible = |eligible;
  assign rr_base      = (arb_mode_p == e_arb_rr) ? rr_ptr_r : '0;
  assign rotated      = num_src_p'({eligible, eligible} >> rr_base);

  // Priority-encode the rotated requests, then map the winner back to a real index.
  always_comb begin
    rot_idx = '0;
    for (int i = num_src_p - 1; i >= 0; i--) begin
      if (rotated[i]) rot_idx = id_w_lp'(i);
    end
    grant_sum = {1'b0, rot_idx} + {1'b0, rr_base};
    if (grant_sum >= num_src_lp) grant_sum = grant_sum - num_src_lp;
    grant = grant_sum[id_w_lp-1:0];
  end

  assign cmd_v_o        = any_eligible & ~fifo_full & ~reset_i;
  assign cmd_o          = src_cmd_i[grant];
  assign handshake      = cmd_v_o & cmd_ready_i;
  assign src_cmd_yumi_o = handshake ? (num_src_p'(1) << grant) : '0;

  assign resp_live    = resp_v_i & ~fifo_empty & ~reset_i;
  assign src_resp_o   = resp_i;
  assign src_resp_v_o = resp_live ? (num_src_p'(1) << head) : '0;
  assign resp_yumi_o  = resp_live & src_resp_ready_i[head];
  assign idle_o       = (outstanding_o == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_r <= '0;
    end else if (handshake && (arb_mode_p == e_arb_rr)) begin
      rr_ptr_r <= (grant == last_src_lp) ? '0 : grant + 1'b1;
    end
  end

  bp_me_arb_id_fifo #(
    .depth_p (max_outstanding_p),
    .width_p (id_w_lp)
  ) id_fifo (
    .clk     (clk_i),
    .rst     (reset_i),
    .push    (handshake),
    .push_id (grant),
    .pop     (resp_yumi_o),
    .head_id (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding_o)
  );

  // A response with nothing in flight has no owner; flag it in simulation.
  resp_without_cmd: assert property (@(posedge clk_i) disable iff (reset_i)
    !(resp_v_i && fifo_empty));

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Directed bench: a fixed-priority 2-source instance and a round-robin
// 3-source instance, both 4 deep, driven on the falling edge and checked 1ns later.
module tb_bp_me_io_cmd_arbiter;
  import bp_me_pkg::*;

  localparam int W = bp_me_mem_msg_width(e_bp_default_cfg);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  logic [1:0]        a_en, a_v, a_yumi, a_rv, a_rrdy;
  logic [1:0][W-1:0] a_cmd;
  logic [W-1:0]      a_sresp, a_cmd_o, a_resp;
  logic              a_cv, a_crdy, a_resp_v, a_ryumi, a_idle;
  logic [2:0]        a_out;

  logic [2:0]        b_en, b_v, b_yumi, b_rv, b_rrdy;
  logic [2:0][W-1:0] b_cmd;
  logic [W-1:0]      b_sresp, b_cmd_o, b_resp;
  logic              b_cv, b_crdy, b_resp_v, b_ryumi, b_idle;
  logic [2:0]        b_out;

  bp_me_io_cmd_arbiter #(.num_src_p(2), .max_outstanding_p(4), .arb_mode_p(e_arb_fixed)) dut_fixed (
    .clk_i(clk), .reset_i(rst), .src_en_i(a_en), .src_cmd_i(a_cmd), .src_cmd_v_i(a_v),
    .src_cmd_yumi_o(a_yumi), .src_resp_o(a_sresp), .src_resp_v_o(a_rv), .src_resp_ready_i(a_rrdy),
    .cmd_o(a_cmd_o), .cmd_v_o(a_cv), .cmd_ready_i(a_crdy), .resp_i(a_resp), .resp_v_i(a_resp_v),
    .resp_yumi_o(a_ryumi), .outstanding_o(a_out), .idle_o(a_idle));

  bp_me_io_cmd_arbiter #(.num_src_p(3), .max_outstanding_p(4), .arb_mode_p(e_arb_rr)) dut_rr (
    .clk_i(clk), .reset_i(rst), .src_en_i(b_en), .src_cmd_i(b_cmd), .src_cmd_v_i(b_v),
    .src_cmd_yumi_o(b_yumi), .src_resp_o(b_sresp), .src_resp_v_o(b_rv), .src_resp_ready_i(b_rrdy),
    .cmd_o(b_cmd_o), .cmd_v_o(b_cv), .cmd_ready_i(b_crdy), .resp_i(b_resp), .resp_v_i(b_resp_v),
    .resp_yumi_o(b_ryumi), .outstanding_o(b_out), .idle_o(b_idle));

  function automatic logic [W-1:0] word(input logic [7:0] tag, input int idx);
    return W'({tag, 8'(idx)});
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    a_en = 2'b11; a_v = 2'b11; a_crdy = 1'b1; a_resp_v = 1'b0; a_rrdy = 2'b11;
    b_en = 3'b111; b_v = 3'b111; b_crdy = 1'b1; b_resp_v = 1'b0; b_rrdy = 3'b111;
    for (int i = 0; i < 2; i++) a_cmd[i] = word(8'hA0, i);
    for (int i = 0; i < 3; i++) b_cmd[i] = word(8'hB0, i);
    a_resp = '0; b_resp = '0;
    #3;
    checks++; if (a_cv !== 1'b0) begin errors++; $display("FAIL reset_a_cmd_v got %b want 0", a_cv); end
    checks++; if (a_yumi !== 2'b00) begin errors++; $display("FAIL reset_a_yumi got %b want 00", a_yumi); end
    checks++; if (b_cv !== 1'b0) begin errors++; $display("FAIL reset_b_cmd_v got %b want 0", b_cv); end
    checks++; if (a_out !== 3'd0 || a_idle !== 1'b1) begin errors++; $display("FAIL reset_a_idle got out=%0d idle=%b want 0/1", a_out, a_idle); end
    checks++; if (b_out !== 3'd0 || b_idle !== 1'b1) begin errors++; $display("FAIL reset_b_idle got out=%0d idle=%b want 0/1", b_out, b_idle); end
    @(negedge clk);
    rst = 1'b0;
    a_v = 2'b00; b_v = 3'b000;
  endtask

  task automatic test_fixed_priority();
    @(negedge clk);
    a_en = 2'b11; a_v = 2'b11; a_crdy = 1'b0; a_resp_v = 1'b0; a_rrdy = 2'b11;
    #1;
    checks++; if (a_cv !== 1'b1 || a_yumi !== 2'b00) begin errors++; $display("FAIL fixed_not_ready got v=%b yumi=%b want 1/00", a_cv, a_yumi); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      a_crdy = 1'b1; a_resp_v = (c > 0);
      #1;
      checks++; if (a_yumi !== 2'b01 || a_cmd_o !== word(8'hA0, 0)) begin errors++; $display("FAIL fixed_grant c%0d got yumi=%b cmd=%h want 01/%h", c, a_yumi, a_cmd_o, word(8'hA0, 0)); end
      checks++; if (a_out !== ((c == 0) ? 3'd0 : 3'd1)) begin errors++; $display("FAIL fixed_out c%0d got %0d want %0d", c, a_out, (c == 0) ? 0 : 1); end
      if (c > 0) begin
        checks++; if (a_rv !== 2'b01 || a_ryumi !== 1'b1) begin errors++; $display("FAIL fixed_resp c%0d got rv=%b yumi=%b want 01/1", c, a_rv, a_ryumi); end
      end
    end
    @(negedge clk);
    a_v = 2'b10;
    #1;
    checks++; if (a_yumi !== 2'b10 || a_cmd_o !== word(8'hA0, 1)) begin errors++; $display("FAIL fixed_src1 got yumi=%b cmd=%h want 10/%h", a_yumi, a_cmd_o, word(8'hA0, 1)); end
    checks++; if (a_rv !== 2'b01) begin errors++; $display("FAIL fixed_resp_head0 got %b want 01", a_rv); end
    @(negedge clk);
    a_v = 2'b00;
    #1;
    checks++; if (a_cv !== 1'b0 || a_rv !== 2'b10) begin errors++; $display("FAIL fixed_drain got v=%b rv=%b want 0/10", a_cv, a_rv); end
    @(negedge clk);
    a_resp_v = 1'b0;
    #1;
    checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL fixed_idle got %b want 1", a_idle); end
  endtask

  task automatic test_round_robin();
    int g [10] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      b_en = 3'b111; b_v = (k < 6) ? 3'b111 : 3'b101; b_crdy = 1'b1;
      b_resp_v = (k > 0); b_rrdy = 3'b111;
      #1;
      checks++; if (b_yumi !== (3'b001 << g[k]) || b_cmd_o !== word(8'hB0, g[k])) begin errors++; $display("FAIL rr_grant k%0d got yumi=%b cmd=%h want %b/%h", k, b_yumi, b_cmd_o, 3'b001 << g[k], word(8'hB0, g[k])); end
      if (k > 0) begin
        checks++; if (b_rv !== (3'b001 << g[k-1])) begin errors++; $display("FAIL rr_resp k%0d got %b want %b", k, b_rv, 3'b001 << g[k-1]); end
      end
    end
    @(negedge clk);
    b_v = 3'b000;
    #1;
    checks++; if (b_rv !== 3'b100 || b_ryumi !== 1'b1) begin errors++; $display("FAIL rr_drain got rv=%b yumi=%b want 100/1", b_rv, b_ryumi); end
    @(negedge clk);
    b_resp_v = 1'b0;
  endtask

  task automatic test_outstanding_limit();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_en = 2'b11; a_v = 2'b01; a_crdy = 1'b1; a_resp_v = 1'b0; a_rrdy = 2'b11;
      #1;
      checks++; if (a_yumi !== 2'b01 || a_out !== 3'(k)) begin errors++; $display("FAIL limit_fill k%0d got yumi=%b out=%0d want 01/%0d", k, a_yumi, a_out, k); end
    end
    @(negedge clk);
    #1;
    checks++; if (a_cv !== 1'b0 || a_yumi !== 2'b00 || a_out !== 3'd4) begin errors++; $display("FAIL limit_full got v=%b yumi=%b out=%0d want 0/00/4", a_cv, a_yumi, a_out); end
    @(negedge clk);
    a_resp_v = 1'b1;
    #1;
    checks++; if (a_ryumi !== 1'b1 || a_cv !== 1'b0 || a_yumi !== 2'b00) begin errors++; $display("FAIL limit_pop_no_push got ryumi=%b v=%b yumi=%b want 1/0/00", a_ryumi, a_cv, a_yumi); end
    @(negedge clk);
    a_resp_v = 1'b0;
    #1;
    checks++; if (a_yumi !== 2'b01 || a_out !== 3'd3) begin errors++; $display("FAIL limit_refill got yumi=%b out=%0d want 01/3", a_yumi, a_out); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_v = 2'b00; a_resp_v = 1'b1;
      #1;
      checks++; if (a_ryumi !== 1'b1 || a_out !== 3'(4 - k)) begin errors++; $display("FAIL limit_drain k%0d got ryumi=%b out=%0d want 1/%0d", k, a_ryumi, a_out, 4 - k); end
    end
    @(negedge clk);
    a_resp_v = 1'b0;
    #1;
    checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL limit_idle got %b want 1", a_idle); end
  endtask

  task automatic test_interleave();
    logic [1:0]   src_v  [3] = '{2'b10, 2'b01, 2'b10};
    logic [W-1:0] resp_w [3] = '{word(8'hEA, 0), word(8'hEB, 0), word(8'hEC, 0)};
    logic [1:0]   dest   [3] = '{2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_en = 2'b11; a_v = src_v[k]; a_crdy = 1'b1; a_resp_v = 1'b0;
      #1;
      checks++; if (a_yumi !== src_v[k]) begin errors++; $display("FAIL inter_issue k%0d got %b want %b", k, a_yumi, src_v[k]); end
    end
    @(negedge clk);
    a_v = 2'b00; a_resp_v = 1'b1; a_resp = resp_w[0]; a_rrdy = 2'b01;
    #1;
    checks++; if (a_rv !== 2'b10 || a_ryumi !== 1'b0) begin errors++; $display("FAIL inter_stall got rv=%b yumi=%b want 10/0", a_rv, a_ryumi); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_resp = resp_w[k]; a_rrdy = 2'b11;
      #1;
      checks++; if (a_rv !== dest[k] || a_ryumi !== 1'b1 || a_sresp !== resp_w[k]) begin errors++; $display("FAIL inter_route k%0d got rv=%b yumi=%b data=%h want %b/1/%h", k, a_rv, a_ryumi, a_sresp, dest[k], resp_w[k]); end
    end
    @(negedge clk);
    a_resp_v = 1'b0;
    #1;
    checks++; if (a_out !== 3'd0) begin errors++; $display("FAIL inter_out got %0d want 0", a_out); end
  endtask

  task automatic test_enable_swap();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      a_en = 2'b01; a_v = 2'b11; a_crdy = 1'b1; a_resp_v = 1'b0; a_rrdy = 2'b11;
      #1;
      checks++; if (a_yumi !== 2'b01 || a_out !== 3'(k)) begin errors++; $display("FAIL swap_src0 k%0d got yumi=%b out=%0d want 01/%0d", k, a_yumi, a_out, k); end
    end
    @(negedge clk);
    a_v = 2'b10;
    #1;
    checks++; if (a_cv !== 1'b0 || a_yumi !== 2'b00) begin errors++; $display("FAIL swap_blocked got v=%b yumi=%b want 0/00", a_cv, a_yumi); end
    @(negedge clk);
    a_en = 2'b10; a_resp_v = 1'b1;
    #1;
    checks++; if (a_yumi !== 2'b10 || a_rv !== 2'b01 || a_ryumi !== 1'b1) begin errors++; $display("FAIL swap_cross got yumi=%b rv=%b ryumi=%b want 10/01/1", a_yumi, a_rv, a_ryumi); end
    @(negedge clk);
    a_v = 2'b00;
    #1;
    checks++; if (a_rv !== 2'b01) begin errors++; $display("FAIL swap_pending got %b want 01", a_rv); end
    @(negedge clk);
    #1;
    checks++; if (a_rv !== 2'b10) begin errors++; $display("FAIL swap_src1_resp got %b want 10", a_rv); end
    @(negedge clk);
    a_resp_v = 1'b0; a_en = 2'b00;
    #1;
    checks++; if (a_idle !== 1'b1) begin errors++; $display("FAIL swap_idle got %b want 1", a_idle); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    b_en = 3'b111; b_v = 3'b001; b_crdy = 1'b1; b_resp_v = 1'b0; b_rrdy = 3'b000;
    #1;
    checks++; if (b_yumi !== 3'b001) begin errors++; $display("FAIL areset_issue0 got %b want 001", b_yumi); end
    @(negedge clk);
    b_v = 3'b010;
    #1;
    checks++; if (b_yumi !== 3'b010) begin errors++; $display("FAIL areset_issue1 got %b want 010", b_yumi); end
    @(negedge clk);
    b_v = 3'b111; b_resp_v = 1'b1;
    #1;
    checks++; if (b_out !== 3'd2 || b_cv !== 1'b1) begin errors++; $display("FAIL areset_pre got out=%0d v=%b want 2/1", b_out, b_cv); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (b_out !== 3'd0 || b_idle !== 1'b1) begin errors++; $display("FAIL areset_clear got out=%0d idle=%b want 0/1", b_out, b_idle); end
    checks++; if (b_cv !== 1'b0 || b_yumi !== 3'b000 || b_rv !== 3'b000 || b_ryumi !== 1'b0) begin errors++; $display("FAIL areset_valids got v=%b yumi=%b rv=%b ryumi=%b want all 0", b_cv, b_yumi, b_rv, b_ryumi); end
    @(negedge clk);
    rst = 1'b0; b_resp_v = 1'b0; b_rrdy = 3'b111;
    #1;
    checks++; if (b_yumi !== 3'b001) begin errors++; $display("FAIL areset_rr_ptr got %b want 001", b_yumi); end
    @(negedge clk);
    b_v = 3'b000; b_resp_v = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_outstanding_limit();
    test_interleave();
    test_enable_swap();
    test_async_reset();
    @(negedge clk);
    b_resp_v = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
